l1d_fifo_enq_arbiter: RTL
=========================

Name: l1d_fifo_enq_arbiter

Overview:
- Shares the enqueue side of one multi-port FIFO among NUM_REQ requesters (L1D bank pipelines pushing writeback/refill beats).
- Each cycle it packs up to ENQ_WIDTH winners, in round-robin order, contiguously into FIFO lanes 0..k-1.
- Multi-beat bursts (req_last_i=0) lock the FIFO to one owner so that the burst's beats stay adjacent in FIFO order.
- Sits directly in front of the FIFO's enqueue_vld/payload/rdy ports.

Parameters:
- NUM_REQ, 8, number of requesters (>=2).
- ENQ_WIDTH, 2, FIFO enqueue lanes (1..NUM_REQ).
- PAYLOAD_W, 64, payload bits per beat.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush; same signal that drives the FIFO's flush.
- req_vld_i  in  NUM_REQ  per-requester beat valid.
- req_last_i  in  NUM_REQ  beat is the final beat of its burst; single-beat transfers hold this at 1.
- req_payload_i  in  NUM_REQ*PAYLOAD_W  beat payloads, requester r at [r*PAYLOAD_W+:PAYLOAD_W].
- req_rdy_o  out  NUM_REQ  grant; a beat fires when vld&rdy.
- fifo_enq_vld_o  out  ENQ_WIDTH  to FIFO enqueue_vld.
- fifo_enq_payload_o  out  ENQ_WIDTH*PAYLOAD_W  to FIFO enqueue_payload.
- fifo_enq_rdy_i  in  ENQ_WIDTH  from FIFO enqueue_rdy; thermometer (lane i ready implies lanes <i ready). All-ones/all-zeros when the FIFO runs in must-take-all mode.
- locked_o  out  1  FSM is in LOCK.
- lock_owner_o  out  $clog2(NUM_REQ)  current burst owner; 0 when not locked.

Behaviour:
- Reset (rst=0, async):
  - state=ARB, rr_ptr=0, owner=0.
  - All outputs are combinational from state and inputs; with rst asserted they read 0 (req_rdy_o=0, fifo_enq_vld_o=0, locked_o=0).
- Grant logic is zero-latency and purely combinational in the cycle. No input is registered.
- n_rdy = number of set bits in fifo_enq_rdy_i (thermometer count).
- ARB state:
  - Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - The j-th valid requester found (j from 0) is granted lane j, for j < n_rdy.
  - Lane j outputs vld=1 and that requester's payload. Unused lanes output vld=0 and payload=0.
  - Burst rule: if a granted beat has last=0, it must be the final grant that cycle. Scanning stops after it, so the burst's later beats cannot interleave with other requesters.
  - rr_ptr update when at least one beat fires: (index of the last granted requester + 1) mod NUM_REQ. Otherwise rr_ptr holds.
  - A fired beat with last=0 moves the FSM to LOCK, with owner = that requester.
- LOCK state:
  - Only the owner is eligible, and only on lane 0: req_rdy_o[owner] = req_vld_i[owner] & fifo_enq_rdy_i[0].
  - All other lanes carry vld=0 and all other requesters carry rdy=0.
  - When the owner fires a beat with last=1: FSM goes to ARB, rr_ptr = owner+1 mod NUM_REQ, owner=0.
  - An owner bubble (vld=0) keeps the lock.
- flush_i=1 (any state):
  - That cycle all req_rdy_o=0 and all fifo_enq_vld_o=0.
  - Next state: ARB, owner=0. rr_ptr holds.
  - A partially enqueued burst is discarded by the FIFO flush; the requester restarts it.
- Boundaries:
  - fifo_enq_rdy_i=0 → no grants; state and rr_ptr hold.
  - All NUM_REQ valid with ENQ_WIDTH lanes ready → exactly ENQ_WIDTH grants.
  - rr_ptr wrap NUM_REQ-1 → 0.
  - ENQ_WIDTH > number of valid requesters → only the valid requesters are granted; upper lanes show vld=0.
  - A reset asserted mid-burst aborts LOCK immediately.
- Invariants:
  - Grants are contiguous from lane 0.
  - No requester receives more than one lane per cycle.
  - popcount(req_rdy_o & req_vld_i) = popcount(fifo_enq_vld_o).

Test Plan:
1. Round-robin across cycles. NUM_REQ=8, ENQ_WIDTH=2, all valid, last=1, rdy=2'b11 → cycle-by-cycle grants {0,1}, {2,3}, {4,5}, {6,7}, {0,1}; lane0 payload = lower-index winner.
2. Partial readiness. Reqs 1,4,6 valid, rr_ptr=5, rdy=2'b01 → only req 6 granted on lane 0; rr_ptr becomes 7. Next cycle rdy=2'b11 → reqs 1 and 4 granted on lanes 0 and 1 (wrap scan).
3. Burst lock. Req 3 sends 4 beats (last=0,0,0,1) while reqs 0 and 5 stay valid → cycle 1 grants {3}, or {0,3} if rr_ptr=0. Then only req 3 is granted on lane 0 for 3 cycles with lane1 vld=0 and locked_o=1, lock_owner_o=3. After the last beat: ARB with rr_ptr=4; next grants {5,0}.
4. Backpressure and bubble in LOCK. Owner 2 has vld=0 for 2 cycles, then rdy=0 for 2 cycles → no grants for 4 cycles, locked_o stays 1, the other requesters are never granted.
5. Flush mid-burst. LOCK with owner 6 after 2 beats, flush_i=1 for one cycle → that cycle no vld/rdy; next cycle ARB, locked_o=0, rr_ptr unchanged.
6. Async reset. Assert rst=0 between clock edges during LOCK → outputs go to 0 immediately. After release, first grant starts at requester 0.

Source files
------------

// File: rtl/l1d_fifo_enq_arbiter.sv
// l1d_fifo_enq_arbiter: round-robin packing of up to ENQ_WIDTH requester beats into FIFO enqueue lanes, with burst lock
module l1d_fifo_enq_arbiter #(
  parameter int NUM_REQ   = 8,
  parameter int ENQ_WIDTH = 2,
  parameter int PAYLOAD_W = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic [NUM_REQ-1:0]             req_vld_i,
  input  logic [NUM_REQ-1:0]             req_last_i,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_payload_i,
  output logic [NUM_REQ-1:0]             req_rdy_o,
  output logic [ENQ_WIDTH-1:0]           fifo_enq_vld_o,
  output logic [ENQ_WIDTH*PAYLOAD_W-1:0] fifo_enq_payload_o,
  input  logic [ENQ_WIDTH-1:0]           fifo_enq_rdy_i,
  output logic                           locked_o,
  output logic [$clog2(NUM_REQ)-1:0]     lock_owner_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [0:0] ARB  = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;
  logic [0:0]    state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, owner_q, owner_d, last_idx;
  logic          stop, fire;
  int            n_rdy, cnt;
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
    return IW'((int'(x) + 1) % NUM_REQ);
  endfunction
  // stop ends the scan after a non-final burst beat so its later beats stay adjacent
  always_comb begin
    req_rdy_o          = '0;
    fifo_enq_vld_o     = '0;
    fifo_enq_payload_o = '0;
    n_rdy              = 0;
    cnt                = 0;
    stop               = 1'b0;
    last_idx           = rr_q;
    for (int l = 0; l < ENQ_WIDTH; l++) n_rdy += int'(fifo_enq_rdy_i[l]);
    if (rst && !flush_i && state_q == LOCK) begin
      for (int r = 0; r < NUM_REQ; r++)
        if (r == int'(owner_q) && req_vld_i[r] && fifo_enq_rdy_i[0]) begin
          req_rdy_o[r]                    = 1'b1;
          fifo_enq_vld_o[0]               = 1'b1;
          fifo_enq_payload_o[PAYLOAD_W-1:0] = req_payload_i[r*PAYLOAD_W+:PAYLOAD_W];
          stop                            = !req_last_i[r];
        end
    end else if (rst && !flush_i) begin
      for (int k = 0; k < NUM_REQ; k++)
        for (int r = 0; r < NUM_REQ; r++)
          if (r == (int'(rr_q) + k) % NUM_REQ && !stop && req_vld_i[r] && cnt < n_rdy) begin
            req_rdy_o[r] = 1'b1;
            for (int l = 0; l < ENQ_WIDTH; l++)
              if (l == cnt) begin
                fifo_enq_vld_o[l]                        = 1'b1;
                fifo_enq_payload_o[l*PAYLOAD_W+:PAYLOAD_W] = req_payload_i[r*PAYLOAD_W+:PAYLOAD_W];
              end
            last_idx = IW'(r);
            cnt      = cnt + 1;
            stop     = !req_last_i[r];
          end
    end
  end
  assign fire         = |req_rdy_o;
  assign locked_o     = rst && state_q == LOCK;
  assign lock_owner_o = rst ? owner_q : '0;
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    if (flush_i) begin
      state_d = ARB;
      owner_d = '0;
    end else if (fire && state_q == LOCK) begin
      if (!stop) begin
        state_d = ARB;
        rr_d    = nxt(owner_q);
        owner_d = '0;
      end
    end else if (fire) begin
      rr_d    = nxt(last_idx);
      state_d = stop ? LOCK : ARB;
      owner_d = stop ? last_idx : '0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB;
      rr_q    <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end
endmodule
